// File: rtl/floating_point_divider_pkg.sv
// Shared definitions for the floating-point arithmetic blocks: divider FSM states,
// derived width constants and constructors for the special encodings.
package floating_point_divider_pkg;

    typedef enum logic [1:0] {StIdle, StDivide, StRound, StDone} div_state_e;

    // Constructors return a wide vector; callers size-cast to their own format width.
    localparam int unsigned MaxWidth = 64;

    function automatic int unsigned q_bits(input int unsigned mw);
        return mw + 3;
    endfunction

    function automatic int unsigned exp_bias(input int unsigned ew);
        return (32'd1 << (ew - 1)) - 32'd1;
    endfunction

    function automatic logic [MaxWidth-1:0] inf_value(input logic sign, input int unsigned ew,
                                                      input int unsigned mw);
        logic [MaxWidth-1:0] r;
        r = ((MaxWidth'(1) << ew) - MaxWidth'(1)) << mw;
        return r | (MaxWidth'(sign) << (ew + mw));
    endfunction

    function automatic logic [MaxWidth-1:0] qnan_value(input int unsigned ew,
                                                       input int unsigned mw);
        return inf_value(1'b1, ew, mw) | (MaxWidth'(1) << (mw - 1));
    endfunction

    function automatic logic [MaxWidth-1:0] zero_value(input logic sign, input int unsigned ew,
                                                       input int unsigned mw);
        return MaxWidth'(sign) << (ew + mw);
    endfunction

endpackage

// File: rtl/fp_mantissa_div_step.sv
// One restoring-division iteration: conditional subtract, then shift the remainder.
module fp_mantissa_div_step #(
    parameter int unsigned Width = 25
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] divisor_i,
    output logic             q_bit_o,
    output logic [Width-1:0] rem_o
);
    logic [Width-1:0] rem_sub;

    assign q_bit_o = (rem_i >= divisor_i);
    assign rem_sub = q_bit_o ? (rem_i - divisor_i) : rem_i;
    assign rem_o   = rem_sub << 1;
endmodule

// File: rtl/is_special_float.sv
// Classifies the magnitude part {exp, frac} of a float; exponent 0 counts as zero.
module is_special_float #(
    parameter int unsigned ExpWidth  = 8,
    parameter int unsigned MantWidth = 23
) (
    input  logic [ExpWidth+MantWidth-1:0] operand_i,
    output logic                          is_zero_o,
    output logic                          is_inf_o,
    output logic                          is_nan_o,
    output logic                          is_snan_o
);
    logic [ExpWidth-1:0]  exp_field;
    logic [MantWidth-1:0] frac_field;

    assign exp_field  = operand_i[ExpWidth+MantWidth-1:MantWidth];
    assign frac_field = operand_i[MantWidth-1:0];

    assign is_zero_o = (exp_field == '0);
    assign is_inf_o  = (&exp_field) && (frac_field == '0);
    assign is_nan_o  = (&exp_field) && (frac_field != '0);
    assign is_snan_o = is_nan_o && !frac_field[MantWidth-1];
endmodule

// File: rtl/result_rounder.sv
// Rounds {exp, mant} using trailing rounding bits; flags a carry into the all-ones exponent.
module result_rounder #(
    parameter int unsigned ExpWidth       = 8,
    parameter int unsigned MantWidth      = 23,
    parameter int unsigned RoundWidth     = 24,
    parameter bit          RoundToNearest = 1'b1
) (
    input  logic [ExpWidth-1:0]   exp_i,
    input  logic [MantWidth-1:0]  mant_i,
    input  logic [RoundWidth-1:0] round_bits_i,
    output logic [ExpWidth-1:0]   exp_o,
    output logic [MantWidth-1:0]  mant_o,
    output logic                  overflow_o
);
    logic round_up;

    // Ties go to the even mantissa.
    assign round_up = RoundToNearest ?
        (round_bits_i[RoundWidth-1] && ((round_bits_i[RoundWidth-2:0] != '0) || mant_i[0])) :
        1'b0;

    assign {exp_o, mant_o} = {exp_i, mant_i} + (ExpWidth + MantWidth)'(round_up);
    assign overflow_o      = &exp_o;
endmodule

// File: rtl/floating_point_divider.sv
// Iterative restoring floating-point divider, one quotient bit per clock, with
// valid/ready handshakes on operands and result.
module floating_point_divider
    import floating_point_divider_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter bit          ROUND_TO_NEAREST = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  b,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  out,
    output logic                                    underflow_flag,
    output logic                                    overflow_flag,
    output logic                                    invalid_operation_flag,
    output logic                                    divide_by_zero_flag
);
    localparam int unsigned EW    = EXPONENT_WIDTH;
    localparam int unsigned MW    = MANTISSA_WIDTH;
    localparam int unsigned W     = EW + MW + 1;
    localparam int unsigned QBits = q_bits(MW);
    localparam int unsigned RemW  = MW + 2;
    localparam int unsigned CntW  = $clog2(QBits);
    localparam logic signed [EW+1:0] BiasS   = (EW + 2)'(exp_bias(EW));
    localparam logic signed [EW+1:0] ExpMax  = (EW + 2)'(2 * exp_bias(EW) + 1);
    localparam logic signed [EW+1:0] ExpZero = '0;
    localparam logic signed [EW+1:0] ExpOne  = (EW + 2)'(1);

    div_state_e              state_q;
    logic                    sign_q;
    logic [RemW-1:0]         rem_q, div_q;
    logic [QBits-1:0]        quo_q;
    logic signed [EW+1:0]    exp_q;
    logic [CntW-1:0]         cnt_q;
    logic                    out_valid_q, unf_q, ovf_q, inv_q, dbz_q;
    logic [W-1:0]            out_q;

    logic a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
    logic res_sign, spec_hit, spec_inv, spec_dbz;
    logic [W-1:0] spec_out;

    is_special_float #(.ExpWidth(EW), .MantWidth(MW)) u_class_a (
        .operand_i (a[W-2:0]),
        .is_zero_o (a_zero),
        .is_inf_o  (a_inf),
        .is_nan_o  (a_nan),
        .is_snan_o (a_snan)
    );

    is_special_float #(.ExpWidth(EW), .MantWidth(MW)) u_class_b (
        .operand_i (b[W-2:0]),
        .is_zero_o (b_zero),
        .is_inf_o  (b_inf),
        .is_nan_o  (b_nan),
        .is_snan_o (b_snan)
    );

    assign res_sign = a[W-1] ^ b[W-1];

    // inf/0 is checked before x/0 so it yields infinity without divide-by-zero.
    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        spec_out = '0;
        if (a_nan || b_nan) begin
            spec_out = W'(qnan_value(EW, MW));
            spec_inv = a_snan || b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_out = W'(qnan_value(EW, MW));
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_out = W'(inf_value(res_sign, EW, MW));
        end else if (b_zero) begin
            spec_out = W'(inf_value(res_sign, EW, MW));
            spec_dbz = 1'b1;
        end else if (b_inf || a_zero) begin
            spec_out = W'(zero_value(res_sign, EW, MW));
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic            q_bit;
    logic [RemW-1:0] rem_step;

    fp_mantissa_div_step #(.Width(RemW)) u_step (
        .rem_i     (rem_q),
        .divisor_i (div_q),
        .q_bit_o   (q_bit),
        .rem_o     (rem_step)
    );

    logic [QBits-2:0]     q_frac;
    logic signed [EW+1:0] e_norm;
    logic [MW:0]          rnd_bits;
    logic [EW-1:0]        rnd_exp;
    logic [MW-1:0]        rnd_mant;
    logic                 rnd_ovf;

    // Quotient lies in (0.5, 2); a zero integer bit means one normalising shift.
    always_comb begin
        if (quo_q[QBits-1]) begin
            q_frac = quo_q[QBits-2:0];
            e_norm = exp_q;
        end else begin
            q_frac = {quo_q[QBits-3:0], 1'b0};
            e_norm = exp_q - ExpOne;
        end
    end

    assign rnd_bits = {q_frac[1], q_frac[0] | (|rem_q), {(MW - 1){1'b0}}};

    result_rounder #(
        .ExpWidth       (EW),
        .MantWidth      (MW),
        .RoundWidth     (MW + 1),
        .RoundToNearest (ROUND_TO_NEAREST)
    ) u_rounder (
        .exp_i        (e_norm[EW-1:0]),
        .mant_i       (q_frac[QBits-2:2]),
        .round_bits_i (rnd_bits),
        .exp_o        (rnd_exp),
        .mant_o       (rnd_mant),
        .overflow_o   (rnd_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            {unf_q, ovf_q, inv_q, dbz_q} <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (in_valid) begin
                    sign_q <= res_sign;
                    if (spec_hit) begin
                        out_q       <= spec_out;
                        {unf_q, ovf_q, inv_q, dbz_q} <= {2'b00, spec_inv, spec_dbz};
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        rem_q   <= {2'b01, a[MW-1:0]};
                        div_q   <= {2'b01, b[MW-1:0]};
                        exp_q   <= $signed({2'b00, a[W-2:MW]}) - $signed({2'b00, b[W-2:MW]})
                                   + BiasS;
                        quo_q   <= '0;
                        cnt_q   <= CntW'(QBits - 1);
                        state_q <= StDivide;
                    end
                end
                StDivide: begin
                    quo_q <= {quo_q[QBits-2:0], q_bit};
                    rem_q <= rem_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= StRound;
                end
                StRound: begin
                    {unf_q, ovf_q, inv_q, dbz_q} <= '0;
                    if (e_norm >= ExpMax) begin
                        out_q <= W'(inf_value(sign_q, EW, MW));
                        ovf_q <= 1'b1;
                    end else if (e_norm <= ExpZero) begin
                        out_q <= W'(zero_value(sign_q, EW, MW));
                        unf_q <= 1'b1;
                    end else if (rnd_ovf) begin
                        out_q <= W'(inf_value(sign_q, EW, MW));
                        ovf_q <= 1'b1;
                    end else begin
                        out_q <= {sign_q, rnd_exp, rnd_mant};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready               = (state_q == StIdle) && !rst;
    assign out_valid              = out_valid_q;
    assign out                    = out_q;
    assign underflow_flag         = unf_q;
    assign overflow_flag          = ovf_q;
    assign invalid_operation_flag = inv_q;
    assign divide_by_zero_flag    = dbz_q;
endmodule

// File: tb/tb_floating_point_divider.sv
// Scoreboard bench for floating_point_divider: a round-to-nearest and a truncating
// instance run side by side on the same FP32 operand stream.
module tb_floating_point_divider;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, unf, ovf, inv, dbz;
    logic        t_in_ready, t_out_valid, t_unf, t_ovf, t_inv, t_dbz;
    logic [31:0] out, t_out;
    logic [3:0]  flags, t_flags;

    assign flags   = {unf, ovf, inv, dbz};
    assign t_flags = {t_unf, t_ovf, t_inv, t_dbz};

    floating_point_divider #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1'b1))
    dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .underflow_flag(unf),
        .overflow_flag(ovf), .invalid_operation_flag(inv), .divide_by_zero_flag(dbz)
    );

    floating_point_divider #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1'b0))
    dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .a(a), .b(b),
        .out_valid(t_out_valid), .out_ready(out_ready), .out(t_out), .underflow_flag(t_unf),
        .overflow_flag(t_ovf), .invalid_operation_flag(t_inv), .divide_by_zero_flag(t_dbz)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] FNone = 4'b0000, FDbz = 4'b0001, FInv = 4'b0010;
    localparam logic [3:0] FOvf = 4'b0100, FUnf = 4'b1000;

    typedef struct {
        logic [31:0] o;
        logic [31:0] t;
        logic [3:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, n_vec = 0, n_cmp = 0, n_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each result handshake.
    initial begin : monitor
        bit seen = 0;
        int first = 0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: out_valid 1 with no operation pending, out %h",
                             out);
                end else begin
                    if (!seen) begin
                        seen  = 1;
                        first = cyc;
                    end
                    check("hold_out", out, sb[0].o);
                    check("hold_flags", 32'(flags), 32'(sb[0].f));
                    check("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        check("latency", 32'(first - sb[0].acc), 32'(sb[0].lat));
                        check("trunc_valid", 32'(t_out_valid), 32'd1);
                        check("trunc_out", t_out, sb[0].t);
                        check("trunc_flags", 32'(t_flags), 32'(sb[0].f));
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] eo,
                         input logic [31:0] et, input logic [3:0] ef, input int lat,
                         input bit push);
        int   guard;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready %b, required 1 for %h / %h", in_ready, va, vb);
        end else begin
            n_vec++;
            if (push) begin
                e.o   = eo;
                e.t   = et;
                e.f   = ef;
                e.lat = lat;
                e.acc = cyc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'({out_valid, t_out_valid}), 32'd0);
        check("reset_out", out, 32'h0);
        check("reset_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'({in_ready, t_in_ready}), 32'd3);

        // Result held for 10 cycles with the consumer stalled.
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, FNone, 28, 1);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("stall_valid_seen", 32'(out_valid), 32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Back-to-back directed vectors.
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, FNone, 28, 1);
        issue(32'hC0400000, 32'h3F800000, 32'hC0400000, 32'hC0400000, FNone, 28, 1);
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, FDbz, 1, 1);
        issue(32'hBF800000, 32'h00000000, 32'hFF800000, 32'hFF800000, FDbz, 1, 1);
        issue(32'h00000000, 32'h00000000, 32'hFFC00000, 32'hFFC00000, FInv, 1, 1);
        issue(32'h7F800000, 32'h7F800000, 32'hFFC00000, 32'hFFC00000, FInv, 1, 1);
        issue(32'h7F800001, 32'h3F800000, 32'hFFC00000, 32'hFFC00000, FInv, 1, 1);
        issue(32'h3F800000, 32'h7FC00000, 32'hFFC00000, 32'hFFC00000, FNone, 1, 1);
        issue(32'h7F800000, 32'hC0000000, 32'hFF800000, 32'hFF800000, FNone, 1, 1);
        issue(32'h3F800000, 32'h7F800000, 32'h00000000, 32'h00000000, FNone, 1, 1);
        issue(32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000, FNone, 1, 1);
        issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, FOvf, 28, 1);
        issue(32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, FUnf, 28, 1);
        issue(32'h80800000, 32'h40000000, 32'h80000000, 32'h80000000, FUnf, 28, 1);

        // Abort an operation mid-divide; nothing may be presented for it.
        issue(32'h40C00000, 32'h40000000, 32'h0, 32'h0, FNone, 0, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, FNone, 28, 1);

        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/floating_point_divider.md
Name: floating_point_divider

Overview:
Iterative IEEE-754-style divider, out = a / b, parametrizable on exponent and mantissa width. It is the inverse-operation companion to the combinational multiplier.
Restoring division produces one quotient bit per clock, so the area is small; latency is deterministic.
Uses valid/ready handshakes on both sides so it can sit between operand FIFOs and a result collector in the arithmetic pipeline.

Parameters:
EXPONENT_WIDTH, 8, exponent field width
MANTISSA_WIDTH, 23, stored fraction width
ROUND_TO_NEAREST, 1, 0: truncate; 1: round-to-nearest-even

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  divider idle and accepting
a  in  EXPONENT_WIDTH+MANTISSA_WIDTH+1  dividend {sign,exp,frac}
b  in  EXPONENT_WIDTH+MANTISSA_WIDTH+1  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  EXPONENT_WIDTH+MANTISSA_WIDTH+1  quotient
underflow_flag  out  1  result flushed to signed zero
overflow_flag  out  1  result saturated to signed infinity
invalid_operation_flag  out  1  sNaN operand, 0/0 or inf/inf
divide_by_zero_flag  out  1  finite nonzero / zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; out_valid, out and all flags 0. in_ready is 0 while rst is high.
- States: IDLE, DIVIDE, ROUND, DONE.
  - in_ready = (state==IDLE) && !rst.
  - Accept happens on the edge where in_valid && in_ready; a and b are registered on that edge.
- Classification at accept, with exponent==0 treated as zero (subnormals flushed):
  - Either operand NaN -> quiet_nan {1, all-ones exp, 1, zeros}. invalid=1 if either operand is sNaN.
  - 0/0 or inf/inf -> quiet_nan, invalid=1.
  - Finite nonzero / 0 -> inf with sign a^b, divide_by_zero=1.
  - inf/finite -> signed inf, no flag.
  - finite/inf or 0/nonzero -> signed zero, no flag.
  - Every special case goes directly to DONE: out_valid is high on the cycle after accept (latency 1).
- Normal path:
  - sign = a^b.
  - Signed exponent, width EXPONENT_WIDTH+2: e = ea - eb + bias.
  - Dividend {1,ma} and divisor {1,mb} are loaded into a remainder register of width MANTISSA_WIDTH+2.
- DIVIDE state:
  - Q_BITS = MANTISSA_WIDTH+3 iterations: 1 integer bit, MANTISSA_WIDTH fraction bits, guard, round.
  - Each cycle: if rem >= divisor, q bit = 1 and rem -= divisor; then rem <<= 1.
  - A down-counter from Q_BITS-1 to 0 controls the loop; leave DIVIDE when the counter reaches 0.
- ROUND state (1 cycle):
  - If q integer bit is 0, shift q left by 1 and e -= 1.
  - sticky = (rem != 0).
  - Check order: if e >= all-ones -> signed inf, overflow=1. Else if e <= 0 -> signed zero, underflow=1. Else pass to the rounder.
  - Rounder inputs: non-rounded mantissa, plus rounding bits {guard, round|sticky, zeros}.
  - Rounder carry-out into an all-ones exponent -> inf, overflow=1.
  - Registers out and flags, then goes to DONE.
- Normal latency: accept edge + Q_BITS + 2 edges. FP32: out_valid asserted 28 cycles after accept.
- DONE state:
  - out_valid=1. out and flags are held stable until out_ready.
  - On out_valid && out_ready -> IDLE, out_valid=0. out and flags retain their values.
  - No accept in the same cycle, because in_ready=0 in DONE.
- Flags are valid only while out_valid=1. Flags are mutually exclusive per result.
- rst in any state: abandon the operation. Next state IDLE, out_valid=0, flags=0. No partial result is ever presented.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Decomposition:
- Shared package:
  - State enum (IDLE/DIVIDE/ROUND/DONE).
  - Q_BITS and bias derived constants.
  - quiet_nan / infinity / zero constructors, parametrized on widths. Shared with the multiplier and adder.
- Reuse existing blocks: is_special_float (one instance per operand) and result_rounder, with the rounding-bit width set to MANTISSA_WIDTH+1.
- One new sub-module is natural: fp_mantissa_div_step. It is the combinational single iteration (rem, divisor -> q bit, next rem), unit-testable on its own.

Test Plan:
- Exact division: a=0x40C00000 (6.0), b=0x40000000 (2.0) -> out=0x40400000, all flags 0. out_valid rises exactly 28 cycles after accept.
- Rounding: a=0x3F800000, b=0x40400000 (1/3) -> 0x3EAAAAAB with ROUND_TO_NEAREST=1; 0x3EAAAAAA with ROUND_TO_NEAREST=0.
- Special cases:
  - 0x3F800000/0x00000000 -> 0x7F800000, divide_by_zero=1, latency 1.
  - 0xBF800000/0x00000000 -> 0xFF800000.
  - 0/0 -> 0xFFC00000, invalid=1.
  - 0x7F800000/0x7F800000 -> 0xFFC00000, invalid=1.
- Range:
  - 0x7F000000/0x3E800000 -> 0x7F800000, overflow=1.
  - 0x00800000/0x40000000 -> 0x00000000, underflow=1.
  - 0x80800000/0x40000000 -> 0x80000000, underflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> out and flags stable, in_ready=0. Back-to-back ops complete without loss.
  - Assert rst for 1 cycle mid-DIVIDE -> next cycle out_valid=0, in_ready=1. A following 6.0/2.0 still gives 0x40400000.
